snickerbits: RTL and testbench

- Single-block SHA-256 compression engine.
- Accepts a SHA-256 context (sha256_pkg::ShaContext), fetches one 64-byte message block from an external 32-bit memory, runs the 64-round compression on the context state and returns the updated 256-bit state.
- Sits between a context producer (host/AXI side) and a hash consumer; drives a status LED.

---
 rtl/snickerbits.sv | 166 ++++++++++++++++
 tb/tb_snickerbits.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snickerbits.sv
// Single-block SHA-256 compression engine: takes a context, reads one 64-byte
// block from a 32-bit memory, runs 64 rounds and returns the updated state.
package sha256_pkg;
  typedef struct packed {
    logic [63:0]  length;
    logic [255:0] state;
    logic [31:0]  curlen;
    logic [511:0] buffer;
  } ShaContext;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
endpackage

// Handshakes: a transfer happens on a rising clk_axi edge where both vld and rdy
// are high; a vld, once raised, holds its payload stable until that edge.
module snickerbits #(
  parameter int MEM_AW = 32,
  parameter int ROUNDS = 64
) (
  input  logic                  clk_axi,
  input  logic                  rst,
  output logic                  led,
  output logic                  ctx_rdy,
  input  logic                  ctx_vld,
  input  sha256_pkg::ShaContext ctx,
  output logic                  mem_addr_vld,
  output logic [MEM_AW-1:0]     mem_addr,
  input  logic                  mem_data_vld,
  input  logic [31:0]           mem_data,
  input  logic                  hash_rdy,
  output logic                  hash_vld,
  output logic [255:0]          hash
);
  import sha256_pkg::*;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_ROUNDS, S_FINAL, S_OUT} state_t;
  state_t state, state_next;

  logic [31:0] hreg [8];
  logic [31:0] wv [8];
  logic [31:0] win [16];
  logic [3:0]  req_cnt;
  logic [4:0]  wcnt;
  logic [5:0]  rnd;
  logic [31:0] t1, t2, w_next;
  logic        capture;
  logic        unused_ctx;

  assign unused_ctx   = ^{ctx.length[63:35], ctx.length[2:0], ctx.curlen, ctx.buffer};
  assign ctx_rdy      = (state == S_IDLE) && !rst;
  assign mem_addr_vld = (state == S_FETCH);
  assign hash_vld     = (state == S_OUT);
  assign capture      = ((state == S_FETCH) || (state == S_WAIT)) && mem_data_vld && (wcnt < 5'd16);

  // win[0] is always W[t]; each round appends W[t+16] at the top of the window.
  always_comb begin
    t1     = wv[7] + big_sigma1(wv[4]) + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6])) + K[rnd] + win[0];
    t2     = big_sigma0(wv[0]) + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
    w_next = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];
  end

  always_ff @(posedge clk_axi) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (ctx_vld) state_next = S_FETCH;
      S_FETCH:  if (req_cnt == 4'd15) state_next = S_WAIT;
      S_WAIT:   if (wcnt == 5'd16 || (capture && wcnt == 5'd15)) state_next = S_ROUNDS;
      S_ROUNDS: if (rnd == 6'(ROUNDS - 1)) state_next = S_FINAL;
      S_FINAL:  state_next = S_OUT;
      S_OUT:    if (hash_rdy) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_axi) begin
    if (rst) begin
      led      <= 1'b0;
      mem_addr <= '0;
      hash     <= '0;
      req_cnt  <= '0;
      wcnt     <= '0;
      rnd      <= '0;
      for (int i = 0; i < 8; i++) begin
        hreg[i] <= '0;
        wv[i]   <= '0;
      end
    end else begin
      if (capture) begin
        win[wcnt[3:0]] <= mem_data;
        wcnt           <= wcnt + 5'd1;
      end
      case (state)
        S_IDLE: if (ctx_vld) begin
          // length counts bits already hashed, so the block starts at length/8
          mem_addr <= MEM_AW'(ctx.length[34:3]);
          req_cnt  <= '0;
          wcnt     <= '0;
          rnd      <= '0;
          for (int i = 0; i < 8; i++) begin
            hreg[i] <= ctx.state[32*(7-i) +: 32];
            wv[i]   <= ctx.state[32*(7-i) +: 32];
          end
        end
        S_FETCH: begin
          mem_addr <= mem_addr + MEM_AW'(4);
          req_cnt  <= req_cnt + 4'd1;
        end
        S_ROUNDS: begin
          wv[0] <= t1 + t2;
          wv[1] <= wv[0];
          wv[2] <= wv[1];
          wv[3] <= wv[2];
          wv[4] <= wv[3] + t1;
          wv[5] <= wv[4];
          wv[6] <= wv[5];
          wv[7] <= wv[6];
          for (int i = 0; i < 15; i++) win[i] <= win[i+1];
          win[15] <= w_next;
          rnd     <= rnd + 6'd1;
        end
        S_FINAL: begin
          for (int i = 0; i < 8; i++) begin
            hreg[i]             <= hreg[i] + wv[i];
            hash[32*(7-i) +: 32] <= hreg[i] + wv[i];
          end
        end
        S_OUT: if (hash_rdy) led <= ~led;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_snickerbits.sv
// Scoreboard bench for snickerbits: directed contexts, a latency-configurable
// memory responder, and a monitor that pops expected hashes on each handshake.
module tb_snickerbits;
  logic                  clk_axi = 1'b0;
  logic                  rst;
  logic                  led;
  logic                  ctx_rdy;
  logic                  ctx_vld;
  sha256_pkg::ShaContext ctx;
  logic                  mem_addr_vld;
  logic [31:0]           mem_addr;
  logic                  mem_data_vld;
  logic [31:0]           mem_data;
  logic                  hash_rdy;
  logic                  hash_vld;
  logic [255:0]          hash;

  snickerbits dut (
    .clk_axi(clk_axi), .rst(rst), .led(led), .ctx_rdy(ctx_rdy), .ctx_vld(ctx_vld), .ctx(ctx),
    .mem_addr_vld(mem_addr_vld), .mem_addr(mem_addr), .mem_data_vld(mem_data_vld),
    .mem_data(mem_data), .hash_rdy(hash_rdy), .hash_vld(hash_vld), .hash(hash)
  );

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_HASH = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
  localparam logic [511:0] A_BLK = {16{32'h41414141}};

  // clock / reset block
  always #5 clk_axi = ~clk_axi;
  int cyc = 0;
  always @(posedge clk_axi) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [255:0] exp_q[$];
  logic [31:0]  blk_words [16];
  logic [31:0]  cur_base;
  int           addr_idx;
  int           lat;
  bit           gaps;
  bit           inject_stale;
  logic [31:0]  pend_addr[$];
  int           pend_due[$];
  int           c_acc;
  logic         led_exp;
  bit           chk_led;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp_v);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference compression with a fully expanded 64-entry schedule
  function automatic logic [255:0] sha_model(input logic [255:0] st, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, ch, mj, tt1, tt2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = st[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      s1  = rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25);
      ch  = (v[4] & v[5]) ^ (~v[4] & v[6]);
      tt1 = v[7] + s1 + ch + sha256_pkg::K[t] + w[t];
      s0  = rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22);
      mj  = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      tt2 = s0 + mj;
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + tt1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = tt1 + tt2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = st[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  task automatic set_block(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) blk_words[i] = blk[511 - 32*i -: 32];
  endtask

  // memory responder: checks request addresses, answers in order after lat cycles
  initial begin
    mem_data_vld = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clk_axi);
      if (!rst && mem_addr_vld) begin
        check("mem_addr", 256'(mem_addr), 256'(cur_base + 32'(4 * addr_idx)));
        addr_idx++;
        pend_addr.push_back(mem_addr);
        pend_due.push_back(cyc + lat);
      end
      @(posedge clk_axi);
      #1;
      mem_data_vld = 1'b0;
      if (inject_stale) begin
        mem_data_vld = 1'b1;
        mem_data = 32'hdeadbeef;
        inject_stale = 1'b0;
      end else if (pend_due.size() > 0 && cyc >= pend_due[0] && !(gaps && (cyc % 3 == 0))) begin
        mem_data_vld = 1'b1;
        mem_data = blk_words[((pend_addr[0] - cur_base) >> 2) & 32'd15];
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
    end
  end

  // monitor / scoreboard
  initial begin
    led_exp = 1'b0;
    chk_led = 1'b0;
    forever begin
      @(negedge clk_axi);
      if (rst) begin
        led_exp = 1'b0;
        chk_led = 1'b0;
      end else begin
        if (chk_led) begin
          check("led_toggle", 256'(led), 256'(led_exp));
          chk_led = 1'b0;
        end
        if (hash_vld && hash_rdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL hash_unexpected act=%h exp=none", hash);
          end else begin
            check("hash", hash, exp_q.pop_front());
          end
          led_exp = ~led_exp;
          chk_led = 1'b1;
        end
      end
    end
  end

  // driver tasks
  task automatic send_ctx(input logic [255:0] st, input logic [63:0] len, input logic [255:0] exp_h);
    int n = 0;
    @(negedge clk_axi);
    while (!ctx_rdy && n < 400) begin
      @(negedge clk_axi);
      n++;
    end
    if (!ctx_rdy) begin
      checks++;
      errors++;
      $display("FAIL ctx_rdy_timeout act=0 exp=1");
      return;
    end
    cur_base = len[34:3];
    addr_idx = 0;
    exp_q.push_back(exp_h);
    ctx.state  = st;
    ctx.length = len;
    ctx.curlen = $urandom;
    ctx.buffer = {16{$urandom}};
    ctx_vld = 1'b1;
    c_acc = cyc;
    @(posedge clk_axi);
    #1;
    ctx_vld = 1'b0;
  endtask

  task automatic wait_hash_latency(input int exp_lat);
    int n = 0;
    @(negedge clk_axi);
    while (!hash_vld && n < 300) begin
      @(negedge clk_axi);
      n++;
    end
    check("hash_latency", 256'(cyc - c_acc), 256'(exp_lat));
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk_axi);
      n++;
    end while (!(exp_q.size() == 0 && ctx_rdy) && n < 400);
    check("drain", 256'(exp_q.size()), 256'(0));
    check("req_count", 256'(addr_idx), 256'(16));
  endtask

  initial begin
    logic [255:0] st, e;
    #5000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] st, e;
    rst = 1'b1; ctx_vld = 1'b0; ctx = '0; hash_rdy = 1'b1;
    lat = 1; gaps = 1'b0; inject_stale = 1'b0; cur_base = '0; addr_idx = 0;
    set_block(ABC_BLK);

    // reset held 4 cycles
    repeat (2) @(posedge clk_axi);
    @(negedge clk_axi);
    check("rst_ctx_rdy", 256'(ctx_rdy), 256'(0));
    check("rst_mem_addr_vld", 256'(mem_addr_vld), 256'(0));
    check("rst_mem_addr", 256'(mem_addr), 256'(0));
    check("rst_hash_vld", 256'(hash_vld), 256'(0));
    check("rst_hash", hash, 256'(0));
    check("rst_led", 256'(led), 256'(0));
    repeat (2) @(posedge clk_axi);
    #1 rst = 1'b0;
    @(negedge clk_axi);
    check("post_rst_ctx_rdy", 256'(ctx_rdy), 256'(1));

    // golden "abc" with 1-cycle memory
    send_ctx(IV, 64'd0, ABC_HASH);
    wait_hash_latency(83);
    wait_done();
    check("abc_led", 256'(led), 256'(1));

    // addressing and back-to-back chained contexts
    set_block(A_BLK);
    st = IV;
    for (int n = 0; n < 3; n++) begin
      e = sha_model(st, A_BLK);
      send_ctx(st, 64'(512 + 8 * n), e);
      wait_done();
      st = e;
    end

    // backpressure: hash held, no new context accepted
    set_block(ABC_BLK);
    hash_rdy = 1'b0;
    send_ctx(IV, 64'd0, ABC_HASH);
    wait_hash_latency(83);
    for (int i = 0; i < 10; i++) begin
      check("bp_hash_stable", hash, ABC_HASH);
      check("bp_hash_vld", 256'(hash_vld), 256'(1));
      check("bp_ctx_rdy", 256'(ctx_rdy), 256'(0));
      @(negedge clk_axi);
    end
    @(posedge clk_axi);
    #1 hash_rdy = 1'b1;
    wait_done();
    check("bp_led", 256'(led), 256'(1));

    // reset during ROUNDS aborts, stale response ignored
    send_ctx(IV, 64'd0, ABC_HASH);
    while (cyc < c_acc + 40) @(negedge clk_axi);
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk_axi);
    #1 rst = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    @(negedge clk_axi);
    check("abort_hash_vld", 256'(hash_vld), 256'(0));
    check("abort_led", 256'(led), 256'(0));
    check("abort_ctx_rdy", 256'(ctx_rdy), 256'(1));
    inject_stale = 1'b1;
    repeat (3) @(negedge clk_axi);
    check("stale_hash_vld", 256'(hash_vld), 256'(0));
    check("stale_mem_addr_vld", 256'(mem_addr_vld), 256'(0));
    check("stale_ctx_rdy", 256'(ctx_rdy), 256'(1));

    // variable latency with gaps
    lat = 3;
    gaps = 1'b1;
    send_ctx(IV, 64'd0, ABC_HASH);
    wait_done();
    check("varlat_led", 256'(led), 256'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
